// File: rtl/xbox_def_pkg.sv
// Shared definitions for the xbox accelerator slice: address width, scheduler
// counter width defaults and the batch scheduler state encoding.
package xbox_def_pkg;

    localparam int XMEM_ADDR_WIDTH = 32;

    localparam int DEF_GEN_W  = 16;
    localparam int DEF_GRID_W = 8;
    localparam int DEF_TMO_W  = 24;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ACK,
        SETTLE,
        DONE,
        ERROR
    } sched_state_e;

endpackage

// File: rtl/cgol_sched_wdog.sv
// Per-generation watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches limit-1. A zero limit never expires.
module cgol_sched_wdog #(
    parameter int TMO_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expire = en && (limit != '0) && (count == limit - TMO_W'(1));

endmodule

// File: rtl/cgol_batch_sched.sv
// Batch scheduler: runs the cgol_xlr engine over a list of grids, advancing
// each one a fixed number of generations, with watchdog and abort handling.
module cgol_batch_sched
    import xbox_def_pkg::*;
#(
    parameter int ADDR_W = XMEM_ADDR_WIDTH,
    parameter int GEN_W  = DEF_GEN_W,
    parameter int GRID_W = DEF_GRID_W,
    parameter int TMO_W  = DEF_TMO_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_grid_stride,
    input  logic [GRID_W-1:0] cfg_num_grids,
    input  logic [GEN_W-1:0]  cfg_gen_count,
    input  logic [31:0]       cfg_width,
    input  logic [31:0]       cfg_height,
    input  logic [TMO_W-1:0]  cfg_timeout,
    input  logic              host_start,
    input  logic              host_abort,
    input  logic              host_done_clr,
    output logic [ADDR_W-1:0] eng_base_addr,
    output logic [31:0]       eng_width,
    output logic [31:0]       eng_height,
    output logic              eng_start,
    input  logic              eng_done,
    output logic              eng_done_ack,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              aborted,
    output logic [GRID_W-1:0] cur_grid,
    output logic [GEN_W-1:0]  cur_gen
);

    sched_state_e state, state_next;

    logic [GRID_W-1:0] num_grids_q;
    logic [GEN_W-1:0]  gen_count_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] grid_addr;
    logic [TMO_W-1:0]  timeout_q;
    logic [31:0]       width_q;
    logic [31:0]       height_q;
    logic              abort_pend;

    logic              accept;
    logic              zero_cfg;
    logic              abort_any;
    logic              last_gen;
    logic              last_grid;
    logic              wd_expire;
    logic [GEN_W-1:0]  gen_next;

    assign accept    = host_start && (state == IDLE || state == DONE || state == ERROR);
    assign zero_cfg  = (cfg_num_grids == '0) || (cfg_gen_count == '0);
    assign abort_any = abort_pend || host_abort;
    assign gen_next  = cur_gen + GEN_W'(1);
    assign last_gen  = (gen_next == gen_count_q);
    assign last_grid = (cur_grid == num_grids_q - GRID_W'(1));

    assign eng_base_addr = grid_addr;
    assign eng_width     = width_q;
    assign eng_height    = height_q;

    cgol_sched_wdog #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == LAUNCH),
        .en     (state == WAIT),
        .limit  (timeout_q),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        eng_start    = 1'b0;
        eng_done_ack = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (host_start) begin
                    state_next = zero_cfg ? DONE : LAUNCH;
                end
            end
            LAUNCH: begin
                eng_start  = 1'b1;
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (eng_done) begin
                    state_next = ACK;
                end else if (wd_expire) begin
                    state_next = ERROR;
                end
            end
            ACK: begin
                eng_done_ack = 1'b1;
                busy         = 1'b1;
                state_next   = (abort_any || (last_gen && last_grid)) ? DONE : SETTLE;
            end
            // The engine must drop done before it can take another start.
            SETTLE: begin
                busy = 1'b1;
                if (abort_any) begin
                    state_next = DONE;
                end else if (!eng_done) begin
                    state_next = LAUNCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_grids_q <= '0;
            gen_count_q <= '0;
            stride_q    <= '0;
            grid_addr   <= '0;
            timeout_q   <= '0;
            width_q     <= '0;
            height_q    <= '0;
            abort_pend  <= 1'b0;
            cur_grid    <= '0;
            cur_gen     <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            aborted     <= 1'b0;
        end else if (accept) begin
            num_grids_q <= cfg_num_grids;
            gen_count_q <= cfg_gen_count;
            stride_q    <= cfg_grid_stride;
            grid_addr   <= cfg_base_addr;
            timeout_q   <= cfg_timeout;
            width_q     <= cfg_width;
            height_q    <= cfg_height;
            abort_pend  <= 1'b0;
            cur_grid    <= '0;
            cur_gen     <= '0;
            done        <= zero_cfg;
            err_timeout <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            // Clears come first so that any flag set below on the same cycle wins.
            if (host_done_clr) begin
                done        <= 1'b0;
                err_timeout <= 1'b0;
                aborted     <= 1'b0;
            end
            if (busy && host_abort) begin
                abort_pend <= 1'b1;
            end
            case (state)
                WAIT: begin
                    if (!eng_done && wd_expire) begin
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        abort_pend  <= 1'b0;
                    end
                end
                ACK: begin
                    if (!abort_any && last_gen && !last_grid) begin
                        cur_grid  <= cur_grid + GRID_W'(1);
                        cur_gen   <= '0;
                        grid_addr <= grid_addr + stride_q;
                    end else begin
                        cur_gen <= gen_next;
                    end
                    if (state_next == DONE) begin
                        done       <= 1'b1;
                        abort_pend <= 1'b0;
                        if (abort_any) begin
                            aborted <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (abort_any) begin
                        done       <= 1'b1;
                        aborted    <= 1'b1;
                        abort_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cgol_batch_sched.sv
// Scoreboard bench for cgol_batch_sched: a reference batch model fills expected
// launch-address and end-of-batch queues; a negedge monitor drains them.
module tb_cgol_batch_sched;
    import xbox_def_pkg::*;

    localparam int ADDR_W = XMEM_ADDR_WIDTH;
    localparam int GEN_W  = 16;
    localparam int GRID_W = 8;
    localparam int TMO_W  = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] cfg_base_addr, cfg_grid_stride;
    logic [GRID_W-1:0] cfg_num_grids;
    logic [GEN_W-1:0]  cfg_gen_count;
    logic [31:0]       cfg_width, cfg_height;
    logic [TMO_W-1:0]  cfg_timeout;
    logic              host_start, host_abort, host_done_clr;
    logic [ADDR_W-1:0] eng_base_addr;
    logic [31:0]       eng_width, eng_height;
    logic              eng_start, eng_done, eng_done_ack;
    logic              busy, done, err_timeout, aborted;
    logic [GRID_W-1:0] cur_grid;
    logic [GEN_W-1:0]  cur_gen;

    always #5 clk = ~clk;

    cgol_batch_sched #(
        .ADDR_W (ADDR_W),
        .GEN_W  (GEN_W),
        .GRID_W (GRID_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_grid_stride (cfg_grid_stride),
        .cfg_num_grids   (cfg_num_grids),
        .cfg_gen_count   (cfg_gen_count),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .cfg_timeout     (cfg_timeout),
        .host_start      (host_start),
        .host_abort      (host_abort),
        .host_done_clr   (host_done_clr),
        .eng_base_addr   (eng_base_addr),
        .eng_width       (eng_width),
        .eng_height      (eng_height),
        .eng_start       (eng_start),
        .eng_done        (eng_done),
        .eng_done_ack    (eng_done_ack),
        .busy            (busy),
        .done            (done),
        .err_timeout     (err_timeout),
        .aborted         (aborted),
        .cur_grid        (cur_grid),
        .cur_gen         (cur_gen)
    );

    typedef struct {
        logic              done_f;
        logic              err_f;
        logic              abort_f;
        logic [GRID_W-1:0] grid;
        logic [GEN_W-1:0]  gen;
        int                acks;
    } end_t;

    logic [ADDR_W-1:0] exp_addr_q[$];
    end_t              exp_end_q[$];
    logic [31:0]       exp_w, exp_h;
    int                checks = 0;
    int                errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Engine stand-in: raises done a set number of cycles after start, drops it on ack.
    bit eng_never;
    int eng_fixed_lat;
    int eng_timer;
    always @(posedge clk) begin
        if (rst) begin
            eng_done  <= 1'b0;
            eng_timer <= 0;
        end else begin
            if (eng_done_ack) eng_done <= 1'b0;
            if (eng_start && !eng_never) begin
                eng_timer <= (eng_fixed_lat != 0) ? eng_fixed_lat : int'($urandom_range(4, 15));
            end else if (eng_timer > 0) begin
                eng_timer <= eng_timer - 1;
                if (eng_timer == 1) eng_done <= 1'b1;
            end
        end
    end

    logic [ADDR_W-1:0] mon_addr;
    end_t              mon_end;
    int                ack_cnt;
    logic              done_prev;
    always @(negedge clk) begin
        if (rst) begin
            ack_cnt   = 0;
            done_prev = 1'b0;
        end else begin
            if (eng_start) begin
                checkOutput("eng_start_expected", 64'(exp_addr_q.size() != 0), 64'd1);
                if (exp_addr_q.size() != 0) begin
                    mon_addr = exp_addr_q.pop_front();
                    checkOutput("eng_base_addr", 64'(eng_base_addr), 64'(mon_addr));
                    checkOutput("eng_width_height", {eng_width, eng_height}, {exp_w, exp_h});
                end
            end
            if (eng_done_ack) ack_cnt++;
            if (done && !done_prev) begin
                checkOutput("done_expected", 64'(exp_end_q.size() != 0), 64'd1);
                if (exp_end_q.size() != 0) begin
                    mon_end = exp_end_q.pop_front();
                    checkOutput("end_flags", 64'({done, err_timeout, aborted}),
                                64'({mon_end.done_f, mon_end.err_f, mon_end.abort_f}));
                    checkOutput("end_cur_grid", 64'(cur_grid), 64'(mon_end.grid));
                    checkOutput("end_cur_gen", 64'(cur_gen), 64'(mon_end.gen));
                    checkOutput("end_ack_count", 64'(ack_cnt), 64'(mon_end.acks));
                end
                ack_cnt = 0;
            end
            done_prev = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    task automatic wait_starts(input int count);
        int seen = 0;
        int w = 0;
        while (seen < count && w < 2000) begin
            if (eng_start) seen++;
            if (seen < count) tick();
            w++;
        end
        checkOutput("wait_eng_starts", 64'(seen), 64'(count));
    endtask

    // Reference model: lists every launch address and the end-of-batch status, then runs the batch.
    task automatic applyStimulus(input int g, input int n, input logic [ADDR_W-1:0] base,
                                 input logic [ADDR_W-1:0] stride, input int tmo,
                                 input int abort_gen, input bit never, input int lat);
        end_t e;
        logic [ADDR_W-1:0] a;
        int w;
        logic [ADDR_W-1:0] saved;
        cfg_num_grids   = GRID_W'(g);
        cfg_gen_count   = GEN_W'(n);
        cfg_base_addr   = base;
        cfg_grid_stride = stride;
        cfg_timeout     = TMO_W'(tmo);
        exp_w           = $urandom;
        exp_h           = $urandom;
        cfg_width       = exp_w;
        cfg_height      = exp_h;
        eng_never       = never;
        eng_fixed_lat   = lat;
        e.done_f = 1'b1; e.err_f = 1'b0; e.abort_f = 1'b0;
        e.grid = '0; e.gen = '0; e.acks = 0;
        if (g == 0 || n == 0) begin
        end else if (never) begin
            exp_addr_q.push_back(base);
            e.err_f = 1'b1;
        end else if (abort_gen >= 0) begin
            for (int k = 0; k <= abort_gen; k++) begin
                a = base + ADDR_W'(k / n) * stride;
                exp_addr_q.push_back(a);
            end
            e.abort_f = 1'b1;
            e.grid    = GRID_W'(abort_gen / n);
            e.gen     = GEN_W'(abort_gen % n + 1);
            e.acks    = abort_gen + 1;
        end else begin
            for (int gi = 0; gi < g; gi++) begin
                for (int ni = 0; ni < n; ni++) begin
                    a = base + ADDR_W'(gi) * stride;
                    exp_addr_q.push_back(a);
                end
            end
            e.grid = GRID_W'(g - 1);
            e.gen  = GEN_W'(n);
            e.acks = g * n;
        end
        exp_end_q.push_back(e);

        host_done_clr = 1'b1;
        tick();
        host_done_clr = 1'b0;
        pulse_start();

        if (g == 0 || n == 0) begin
            tick();
            checkOutput("zero_count_done_no_busy", 64'({done, busy}), 64'(2'b10));
        end else if (never) begin
            checkOutput("launch_after_start", 64'(eng_start), 64'd1);
            tick();
            w = 0;
            while (!err_timeout && w < 200) begin
                tick();
                w++;
            end
            checkOutput("timeout_cycles_after_start", 64'(w), 64'(tmo));
        end else if (abort_gen >= 0) begin
            wait_starts(abort_gen + 1);
            tick();
            tick();
            host_abort = 1'b1;
            tick();
            host_abort = 1'b0;
            saved = cfg_base_addr;
            cfg_base_addr = 32'hDEAD_0000;
            pulse_start();
            cfg_base_addr = saved;
        end

        w = 0;
        while (!done && w < 5000) begin
            tick();
            w++;
        end
        checkOutput("batch_finished", 64'(done), 64'd1);
        tick();
        tick();
        checkOutput("launch_queue_drained", 64'(exp_addr_q.size()), 64'd0);
        checkOutput("end_queue_drained", 64'(exp_end_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        checkOutput(name, {busy, done, err_timeout, aborted, eng_start, eng_done_ack,
                           cur_grid, cur_gen, eng_base_addr}, 64'd0);
        checkOutput({name, "_wh"}, {eng_width, eng_height}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit: simulation still running, expected finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        rst = 1'b1;
        cfg_base_addr = '0; cfg_grid_stride = '0; cfg_num_grids = '0; cfg_gen_count = '0;
        cfg_width = '0; cfg_height = '0; cfg_timeout = '0;
        host_start = 1'b0; host_abort = 1'b0; host_done_clr = 1'b0;
        eng_never = 1'b0; eng_fixed_lat = 0;
        exp_w = '0; exp_h = '0;
        repeat (3) tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();

        applyStimulus(1, 3, $urandom, $urandom, 0, -1, 1'b0, 10);
        applyStimulus(3, 2, 32'h100, 32'h400, 0, -1, 1'b0, 0);
        applyStimulus(1, 0, 32'h40, 32'h40, 0, -1, 1'b0, 0);
        applyStimulus(0, 2, 32'h40, 32'h40, 0, -1, 1'b0, 0);
        applyStimulus(1, 2, 32'h2000, 32'h100, 50, -1, 1'b1, 0);
        applyStimulus(1, 5, 32'h3000, 32'h100, 0, 1, 1'b0, 8);
        applyStimulus(3, 2, 32'h4000, 32'h100, 0, 3, 1'b0, 8);
        applyStimulus(3, 1, 32'hFFFF_F800, 32'h0000_0600, 0, -1, 1'b0, 0);

        // Reset in the middle of a generation, then a clean batch.
        applyStimulus(2, 3, 32'h5000, 32'h200, 0, 2, 1'b0, 12);
        exp_end_q.push_back('{done_f: 1'b1, err_f: 1'b0, abort_f: 1'b0, grid: '0, gen: '0, acks: 0});
        exp_addr_q.push_back(32'h7000);
        exp_addr_q.push_back(32'h7000);
        host_done_clr = 1'b1;
        tick();
        host_done_clr = 1'b0;
        cfg_base_addr = 32'h7000; cfg_num_grids = 8'd2; cfg_gen_count = 16'd3; cfg_timeout = '0;
        eng_fixed_lat = 12;
        pulse_start();
        wait_starts(2);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("reset_during_wait");
        rst = 1'b0;
        exp_addr_q.delete();
        exp_end_q.delete();
        tick();
        applyStimulus(2, 2, 32'h8000, 32'h1000, 0, -1, 1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), $urandom, $urandom,
                          (r % 2 == 0) ? 0 : 200, -1, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
